game_seq_ctrl: RTL and testbench
================================

Name: game_seq_ctrl

Overview:
Top-level game-flow sequencer for the paddle/ball/brick playfield.
- Owns game state, lives, BCD score and the ball-step tick.
- Tells the ball/brick datapath when to hold the ball on the paddle, when to advance one step, and when to reload positions or bricks.
- Sits between the button inputs (buttonclk domain) and the playfield datapath; the display scanner reads its outputs.

Parameters:
STEP_DIV, 3, buttonclk cycles per ball step in PLAY (legal 2..15)
MIN_STEP_DIV, 2, lower bound on the step divisor when GAME_SPEEDUP_EN is defined
BRICK_TOTAL, 16, bricks loaded per round (2 rows x 8)

Ports:
buttonclk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  run enable; low = pause (state, counters and edge-detect register frozen; pulse outputs 0)
launch  in  1  throw button, level; rising edge detected internally
ball_lost  in  1  1-cycle pulse from datapath: ball passed paddle row
brick_hit  in  1  1-cycle pulse: one brick removed
bricks_left  in  5  remaining bricks, 0..BRICK_TOTAL
state  out  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5
hold_ball  out  1  ball tracks paddle (high in IDLE and SERVE)
ball_step  out  1  1-cycle pulse: datapath advances ball one position
reposition  out  1  1-cycle pulse: reload paddle x=2, ball x=3, y=2
reload_bricks  out  1  1-cycle pulse: set all bricks present
life  out  3  thermometer: 111, 110, 100, 000
score_ones  out  4  BCD 0..9
score_tens  out  4  BCD 0..9
game_over  out  1  state==OVER
win  out  1  state==WIN

Behaviour:
- Reset values: state=IDLE, life=111, score=00, step counter=0, launch_q=0; ball_step=reposition=reload_bricks=0.
- All outputs are registered; every transition below takes effect one buttonclk after the sampled cause.
- Launch edge: launch_edge = launch & ~launch_q. launch_q updates only when start=1.
- IDLE: start=1 -> SERVE, with reposition and reload_bricks pulsed in that same transition cycle.
- SERVE: launch_edge -> PLAY, step counter cleared to 0.
- PLAY:
  - counter counts 0..div-1 and wraps; ball_step=1 in the cycle the counter equals div-1.
  - First ball_step comes div cycles after entering PLAY.
- Exit priority from PLAY, same cycle:
  - bricks_left==0 -> WIN (wins over ball_lost).
  - else ball_lost -> MISS.
  - ball_lost outside PLAY is ignored.
- MISS (exactly 1 cycle): life shifts left with 0 fill (111->110->100->000) and reposition=1. Next cycle: life==000 -> OVER, else SERVE.
- OVER / WIN: launch_edge -> SERVE with life=111, score=00, reposition=1, reload_bricks=1.
- Scoring: brick_hit increments BCD in any state. Ones wrap 9->0 with tens+1. Saturates at 99 (further hits ignored). A brick_hit in the same cycle as ball_lost is counted.
- Pause: start=0 holds everything. A pulse input arriving while paused is dropped.
- Reset mid-PLAY: immediate return to reset values on the next edge; no pulses issued.

Optional Feature:
GAME_SPEEDUP_EN
- Defined: effective divisor div = STEP_DIV minus (bricks hit this round / 4), floored at MIN_STEP_DIV. The hit tally clears on reload_bricks.
- Undefined: div = STEP_DIV constant; no tally register is synthesized.

Decomposition:
- Package game_pkg: state enum (6 codes above), LIFE_FULL=3'b111, LIFE_DEAD=3'b000, PADDLE_X0=2, BALL_X0=3, BALL_Y0=2, BRICK_TOTAL.
- Sub-module: bcd_score_counter (inc, clr, sat at 99, outputs ones/tens), shared with the display path.

Test Plan:
1. reset, start=1, then launch rise: IDLE -> SERVE (reposition=1, reload_bricks=1) -> PLAY. With STEP_DIV=3, ball_step at PLAY cycles 3, 6, 9.
2. Three ball_lost pulses, each followed by a relaunch: life 110, 100, 000; state SERVE, SERVE, then OVER, with game_over=1 and reposition pulsed each MISS.
3. 12 brick_hit pulses: score 1, 2, ... 9, then 10, 11, 12 (ones=2, tens=1). From 99, one more hit stays at 99.
4. bricks_left=0 and ball_lost in the same PLAY cycle: WIN, life unchanged. Launch rise: SERVE, life=111, score=00.
5. start=0 for 10 cycles in PLAY: no ball_step, counter frozen; resumes at the same phase. launch held high continuously produces only one edge.
6. GAME_SPEEDUP_EN, STEP_DIV=4, MIN_STEP_DIV=2: after 4 hits the step period is 3; after 8 hits it is 2; after 12 hits it stays 2.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the paddle/ball/brick game: state codes,
// life thermometer values and the playfield reload coordinates.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } game_state_e;

  localparam logic [2:0] LIFE_FULL = 3'b111;
  localparam logic [2:0] LIFE_DEAD = 3'b000;

  localparam int PADDLE_X0   = 2;
  localparam int BALL_X0     = 3;
  localparam int BALL_Y0     = 2;
  localparam int BRICK_TOTAL = 16;

  // Thermometer life meter loses its top-most remaining bar.
  function automatic logic [2:0] life_lose(input logic [2:0] life);
    return {life[1:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter with clear and saturation at 99; also used by
// the display path.
module bcd_score_counter (
  input  logic       buttonclk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge buttonclk) begin
    if (reset) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/game_seq_ctrl.sv
// Game-flow sequencer: state, lives, BCD score and ball-step tick.
// Optional GAME_SPEEDUP_EN shortens the step period as bricks are hit.
module game_seq_ctrl
  import game_pkg::*;
#(
  parameter int STEP_DIV     = 3,
  parameter int MIN_STEP_DIV = 2
) (
  input  logic       buttonclk,
  input  logic       reset,
  input  logic       start,
  input  logic       launch,
  input  logic       ball_lost,
  input  logic       brick_hit,
  input  logic [4:0] bricks_left,
  output logic [2:0] state,
  output logic       hold_ball,
  output logic       ball_step,
  output logic       reposition,
  output logic       reload_bricks,
  output logic [2:0] life,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       game_over,
  output logic       win
);

  game_state_e state_q, state_d;
  logic [2:0]  life_q, life_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        launch_q, launch_d;
  logic        step_q, step_d;
  logic        repo_q, repo_d;
  logic        reload_q, reload_d;
  logic        hold_q, hold_d;
  logic        over_q, over_d;
  logic        win_q, win_d;
  logic        score_clr;
  logic        launch_edge;
  logic [3:0]  div;

`ifdef GAME_SPEEDUP_EN
  logic [4:0] tally_q, tally_d;

  // Hits this round; every four hits take one cycle off the step period.
  always_comb begin
    tally_d = tally_q;
    if (start) begin
      if (reload_d)
        tally_d = 5'd0;
      else if (brick_hit && tally_q != 5'd31)
        tally_d = tally_q + 5'd1;
    end
  end

  always_ff @(posedge buttonclk) begin
    if (reset) tally_q <= 5'd0;
    else       tally_q <= tally_d;
  end

  always_comb begin
    if ({2'b00, tally_q[4:2]} + 5'(MIN_STEP_DIV) >= 5'(STEP_DIV))
      div = 4'(MIN_STEP_DIV);
    else
      div = 4'(STEP_DIV) - {1'b0, tally_q[4:2]};
  end
`else
  always_comb begin
    div = 4'(STEP_DIV);
    if (STEP_DIV < MIN_STEP_DIV) div = 4'(MIN_STEP_DIV);
  end
`endif

  assign launch_edge = launch & ~launch_q;

  always_comb begin
    state_d   = state_q;
    life_d    = life_q;
    cnt_d     = cnt_q;
    launch_d  = launch_q;
    step_d    = 1'b0;
    repo_d    = 1'b0;
    reload_d  = 1'b0;
    score_clr = 1'b0;
    if (start) begin
      launch_d = launch;
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_SERVE;
          repo_d   = 1'b1;
          reload_d = 1'b1;
        end
        ST_SERVE: begin
          if (launch_edge) begin
            state_d = ST_PLAY;
            cnt_d   = 4'd0;
          end
        end
        ST_PLAY: begin
          // Clearing the field outranks losing the ball; no step on exit.
          if (bricks_left == 5'd0) begin
            state_d = ST_WIN;
          end else if (ball_lost) begin
            state_d = ST_MISS;
            life_d  = life_lose(life_q);
            repo_d  = 1'b1;
          end else if (cnt_q >= div - 4'd1) begin
            cnt_d  = 4'd0;
            step_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_MISS: begin
          state_d = (life_q == LIFE_DEAD) ? ST_OVER : ST_SERVE;
        end
        ST_OVER, ST_WIN: begin
          if (launch_edge) begin
            state_d   = ST_SERVE;
            life_d    = LIFE_FULL;
            score_clr = 1'b1;
            repo_d    = 1'b1;
            reload_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    hold_d = (state_d == ST_IDLE) || (state_d == ST_SERVE);
    over_d = (state_d == ST_OVER);
    win_d  = (state_d == ST_WIN);
  end

  always_ff @(posedge buttonclk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      life_q   <= LIFE_FULL;
      cnt_q    <= 4'd0;
      launch_q <= 1'b0;
      step_q   <= 1'b0;
      repo_q   <= 1'b0;
      reload_q <= 1'b0;
      hold_q   <= 1'b1;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      life_q   <= life_d;
      cnt_q    <= cnt_d;
      launch_q <= launch_d;
      step_q   <= step_d;
      repo_q   <= repo_d;
      reload_q <= reload_d;
      hold_q   <= hold_d;
      over_q   <= over_d;
      win_q    <= win_d;
    end
  end

  bcd_score_counter u_score (
    .buttonclk (buttonclk),
    .reset     (reset),
    .inc       (start & brick_hit),
    .clr       (score_clr),
    .ones      (score_ones),
    .tens      (score_tens)
  );

  assign state         = state_q;
  assign life          = life_q;
  assign hold_ball     = hold_q;
  assign ball_step     = step_q;
  assign reposition    = repo_q;
  assign reload_bricks = reload_q;
  assign game_over     = over_q;
  assign win           = win_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Self-checking bench for game_seq_ctrl: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural game model.
module tb_game_seq_ctrl;

`ifdef GAME_SPEEDUP_EN
  localparam int SD = 4;
`else
  localparam int SD = 3;
`endif
  localparam int MIN_SD = 2;

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_MISS = 3, M_OVER = 4, M_WIN = 5;

  logic       buttonclk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       launch = 1'b0;
  logic       ball_lost = 1'b0;
  logic       brick_hit = 1'b0;
  logic [4:0] bricks_left = 5'd16;
  logic [2:0] state;
  logic       hold_ball, ball_step, reposition, reload_bricks;
  logic [2:0] life;
  logic [3:0] score_ones, score_tens;
  logic       game_over, win;

  game_seq_ctrl #(.STEP_DIV(SD), .MIN_STEP_DIV(MIN_SD)) dut (
    .buttonclk     (buttonclk),
    .reset         (reset),
    .start         (start),
    .launch        (launch),
    .ball_lost     (ball_lost),
    .brick_hit     (brick_hit),
    .bricks_left   (bricks_left),
    .state         (state),
    .hold_ball     (hold_ball),
    .ball_step     (ball_step),
    .reposition    (reposition),
    .reload_bricks (reload_bricks),
    .life          (life),
    .score_ones    (score_ones),
    .score_tens    (score_tens),
    .game_over     (game_over),
    .win           (win)
  );

  always #5 buttonclk = ~buttonclk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: lives as a count, score as a plain integer,
  // step timing as cycles elapsed since the previous step.
  int m_st = M_IDLE, m_lives = 3, m_score = 0, m_since = 0, m_hits = 0;
  bit m_lprev = 0, m_step = 0, m_repo = 0, m_reload = 0;

  function automatic int m_div();
    int d;
    d = SD;
`ifdef GAME_SPEEDUP_EN
    d = SD - m_hits / 4;
    if (d < MIN_SD) d = MIN_SD;
`endif
    return d;
  endfunction

  function automatic logic [7:0] therm(input int n);
    case (n)
      3:       return 8'h07;
      2:       return 8'h06;
      1:       return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    bit ledge, clr;
    int d;
    m_step = 0; m_repo = 0; m_reload = 0;
    if (reset) begin
      m_st = M_IDLE; m_lives = 3; m_score = 0; m_since = 0; m_hits = 0; m_lprev = 0;
      return;
    end
    if (!start) return;
    d = m_div();
    ledge = launch && !m_lprev;
    m_lprev = launch;
    clr = 0;
    case (m_st)
      M_IDLE: begin m_st = M_SERVE; m_repo = 1; m_reload = 1; end
      M_SERVE: if (ledge) begin m_st = M_PLAY; m_since = 0; end
      M_PLAY: begin
        if (bricks_left == 0) m_st = M_WIN;
        else if (ball_lost) begin m_st = M_MISS; m_lives = m_lives - 1; m_repo = 1; end
        else begin
          m_since = m_since + 1;
          if (m_since >= d) begin m_since = 0; m_step = 1; end
        end
      end
      M_MISS: m_st = (m_lives == 0) ? M_OVER : M_SERVE;
      default: if (ledge) begin
        m_st = M_SERVE; m_lives = 3; clr = 1; m_repo = 1; m_reload = 1;
      end
    endcase
    if (clr) m_score = 0;
    else if (brick_hit && m_score < 99) m_score = m_score + 1;
    if (m_reload) m_hits = 0;
    else if (brick_hit && m_hits < 31) m_hits = m_hits + 1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("state", 8'(state), 8'(m_st));
    chk("life", 8'(life), therm(m_lives));
    chk("score", {score_tens, score_ones}, {4'(m_score / 10), 4'(m_score % 10)});
    chk("ball_step", 8'(ball_step), 8'(m_step));
    chk("reposition", 8'(reposition), 8'(m_repo));
    chk("reload_bricks", 8'(reload_bricks), 8'(m_reload));
    chk("game_over", 8'(game_over), 8'(m_st == M_OVER));
    chk("win", 8'(win), 8'(m_st == M_WIN));
    chk("hold_ball", 8'(hold_ball), 8'(m_st == M_IDLE || m_st == M_SERVE));
  endtask

  task automatic cyc(input bit st, input bit la, input bit bl, input bit bh,
                     input int bleft, input bit rs);
    start = st; launch = la; ball_lost = bl; brick_hit = bh;
    bricks_left = 5'(bleft); reset = rs;
    model_step();
    @(posedge buttonclk);
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] miss_life [3];
    bit la_r;
    miss_life[0] = 8'h06; miss_life[1] = 8'h04; miss_life[2] = 8'h00;

    // Reset values
    cyc(0, 0, 0, 0, 16, 1);
    cyc(0, 0, 0, 0, 16, 1);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_life", 8'(life), 8'h07);
    chk("rst_pulses", {5'd0, ball_step, reposition, reload_bricks}, 8'd0);

    // IDLE -> SERVE -> PLAY, step timing
    cyc(1, 0, 0, 0, 16, 0);
    chk("serve_state", 8'(state), 8'd1);
    chk("serve_reload", {6'd0, reposition, reload_bricks}, 8'h03);
    cyc(1, 1, 0, 0, 16, 0);
    chk("play_state", 8'(state), 8'd2);
    for (int k = 1; k <= 3 * SD; k++) begin
      cyc(1, 1, 0, 0, 16, 0);
      chk("step_phase", 8'(ball_step), 8'(k % SD == 0));
    end

    // Pause: frozen, pulse inputs dropped, then same phase with no new launch edge
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1, 1, 16, 0);
      chk("pause_step", 8'(ball_step), 8'd0);
      chk("pause_state", 8'(state), 8'd2);
    end
    chk("pause_score", {score_tens, score_ones}, 8'h00);
    for (int k = 1; k <= 2 * SD; k++) begin
      cyc(1, 1, 0, 0, 16, 0);
      chk("resume_step", 8'(ball_step), 8'(k % SD == 0));
    end

    // Three misses down to OVER
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 0, 16, 0);
      chk("miss_state", 8'(state), 8'd3);
      chk("miss_life", 8'(life), miss_life[i]);
      chk("miss_repo", 8'(reposition), 8'd1);
      cyc(1, 0, 0, 0, 16, 0);
      chk("after_miss", 8'(state), (i < 2) ? 8'd1 : 8'd4);
      if (i < 2) cyc(1, 1, 0, 0, 16, 0);
    end
    chk("game_over", 8'(game_over), 8'd1);

    // Scoring and saturation
    for (int k = 1; k <= 12; k++) begin
      cyc(1, 0, 0, 1, 16, 0);
      chk("score_bcd", {score_tens, score_ones}, {4'(k / 10), 4'(k % 10)});
    end
    for (int k = 0; k < 100; k++) cyc(1, 0, 0, 1, 16, 0);
    chk("score_sat", {score_tens, score_ones}, 8'h99);

    // Relaunch from OVER
    cyc(1, 1, 0, 0, 16, 0);
    chk("relaunch_state", 8'(state), 8'd1);
    chk("relaunch_life", 8'(life), 8'h07);
    chk("relaunch_score", {score_tens, score_ones}, 8'h00);

    // WIN beats ball_lost in the same cycle
    cyc(1, 0, 0, 0, 16, 0);
    cyc(1, 1, 0, 0, 16, 0);
    cyc(1, 1, 1, 1, 0, 0);
    chk("win_state", 8'(state), 8'd5);
    chk("win_life", 8'(life), 8'h07);
    chk("win_flag", 8'(win), 8'd1);
    cyc(1, 0, 0, 0, 16, 0);
    cyc(1, 1, 0, 0, 16, 0);
    chk("win_relaunch", 8'(state), 8'd1);
    chk("win_relaunch_score", {score_tens, score_ones}, 8'h00);

    // Random play against the model
    la_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) la_r = ~la_r;
      cyc($urandom_range(0, 9) != 0, la_r, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0,
          ($urandom_range(0, 40) == 0) ? 0 : int'($urandom_range(1, 16)),
          $urandom_range(0, 799) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
